// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - golden-trace checker for the CPU write-back debug port
module wb_trace_checker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      debug_wb_pc,
  input  logic [3:0]       debug_wb_rf_wen,
  input  logic [4:0]       debug_wb_rf_wnum,
  input  logic [31:0]      debug_wb_rf_wdata,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_pc,
  input  logic [4:0]       exp_wnum,
  input  logic [31:0]      exp_wdata,
  input  logic [31:0]      end_pc,
  output logic [CNT_W-1:0] cmp_count,
  output logic             err,
  output logic             underflow,
  output logic [31:0]      err_pc,
  output logic [4:0]       err_got_wnum,
  output logic [31:0]      err_got_wdata,
  output logic [31:0]      err_exp_wdata,
  output logic             done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ERR  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
  logic [4:0]       fifo_wnum_q  [FIFO_DEPTH];
  logic [31:0]      fifo_wdata_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] cmp_count_q, cmp_count_d;
  logic             err_q, err_d, underflow_q, underflow_d, done_q, done_d;
  logic [31:0]      err_pc_q, err_pc_d, err_got_wdata_q, err_got_wdata_d;
  logic [31:0]      err_exp_wdata_q, err_exp_wdata_d;
  logic [4:0]       err_got_wnum_q, err_got_wnum_d;

  logic        running, wb_event, fifo_empty, match, push, pop, fail;
  logic [31:0] head_pc, head_wdata, byte_mask;
  logic [4:0]  head_wnum;

  // Ready is forced low while reset is asserted so the stream side never sees a push window mid-reset
  assign running   = (state_q == ST_RUN);
  assign exp_ready = resetn && running && (count_q < DEPTH_C);

  // Event decode and comparison against the registered FIFO head
  always_comb begin
    wb_event   = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    byte_mask  = {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}},
                  {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};
    head_pc    = fifo_pc_q[rd_ptr_q];
    head_wnum  = fifo_wnum_q[rd_ptr_q];
    head_wdata = fifo_wdata_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    match      = !fifo_empty && (debug_wb_pc == head_pc) &&
                 (debug_wb_rf_wnum == head_wnum) &&
                 (((debug_wb_rf_wdata ^ head_wdata) & byte_mask) == 32'd0);
    push       = exp_valid && exp_ready;
    pop        = running && wb_event && match;
    fail       = running && wb_event && !match;
  end

  // Next-state, FIFO bookkeeping and result registers; ERR wins over DONE
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    cmp_count_d     = cmp_count_q;
    err_d           = err_q;
    underflow_d     = underflow_q;
    done_d          = done_q;
    err_pc_d        = err_pc_q;
    err_got_wnum_d  = err_got_wnum_q;
    err_got_wdata_d = err_got_wdata_q;
    err_exp_wdata_d = err_exp_wdata_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      cmp_count_d = cmp_count_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (fail) begin
      state_d         = ST_ERR;
      err_d           = 1'b1;
      underflow_d     = fifo_empty;
      err_pc_d        = debug_wb_pc;
      err_got_wnum_d  = debug_wb_rf_wnum;
      err_got_wdata_d = debug_wb_rf_wdata;
      err_exp_wdata_d = fifo_empty ? 32'd0 : head_wdata;
    end else if (running && (debug_wb_pc == end_pc)) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
    end
  end

  // Control and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_RUN;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      cmp_count_q     <= '0;
      err_q           <= 1'b0;
      underflow_q     <= 1'b0;
      done_q          <= 1'b0;
      err_pc_q        <= 32'd0;
      err_got_wnum_q  <= 5'd0;
      err_got_wdata_q <= 32'd0;
      err_exp_wdata_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      cmp_count_q     <= cmp_count_d;
      err_q           <= err_d;
      underflow_q     <= underflow_d;
      done_q          <= done_d;
      err_pc_q        <= err_pc_d;
      err_got_wnum_q  <= err_got_wnum_d;
      err_got_wdata_q <= err_got_wdata_d;
      err_exp_wdata_q <= err_exp_wdata_d;
    end
  end

  // Expected-entry storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= exp_pc;
      fifo_wnum_q[wr_ptr_q]  <= exp_wnum;
      fifo_wdata_q[wr_ptr_q] <= exp_wdata;
    end
  end

  assign cmp_count     = cmp_count_q;
  assign err           = err_q;
  assign underflow     = underflow_q;
  assign done          = done_q;
  assign err_pc        = err_pc_q;
  assign err_got_wnum  = err_got_wnum_q;
  assign err_got_wdata = err_got_wdata_q;
  assign err_exp_wdata = err_exp_wdata_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - directed self-checking bench for wb_trace_checker
module tb_wb_trace_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_pc;
  logic [4:0]  exp_wnum;
  logic [31:0] exp_wdata;
  logic [31:0] end_pc;
  logic [31:0] cmp_count;
  logic        err, underflow, done;
  logic [31:0] err_pc, err_got_wdata, err_exp_wdata;
  logic [4:0]  err_got_wnum;

  int tests = 0;
  int fails = 0;

  wb_trace_checker #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .exp_valid         (exp_valid),
    .exp_ready         (exp_ready),
    .exp_pc            (exp_pc),
    .exp_wnum          (exp_wnum),
    .exp_wdata         (exp_wdata),
    .end_pc            (end_pc),
    .cmp_count         (cmp_count),
    .err               (err),
    .underflow         (underflow),
    .err_pc            (err_pc),
    .err_got_wnum      (err_got_wnum),
    .err_got_wdata     (err_got_wdata),
    .err_exp_wdata     (err_exp_wdata),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    debug_wb_pc       = 32'd0;
    debug_wb_rf_wen   = 4'd0;
    debug_wb_rf_wnum  = 5'd0;
    debug_wb_rf_wdata = 32'd0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] wdata);
    exp_valid = 1'b1;
    exp_pc    = pc;
    exp_wnum  = wnum;
    exp_wdata = wdata;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic wb_ev(input logic [31:0] pc, input logic [3:0] wen,
                       input logic [4:0] wnum, input logic [31:0] wdata);
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = wen;
    debug_wb_rf_wnum  = wnum;
    debug_wb_rf_wdata = wdata;
    tick();
    clear_wb();
  endtask

  initial begin
    int n;
    resetn    = 1'b0;
    exp_valid = 1'b0;
    exp_pc    = 32'd0;
    exp_wnum  = 5'd0;
    exp_wdata = 32'd0;
    end_pc    = 32'hBFC0_0100;
    clear_wb();

    // reset values
    tick();
    check("rst_ready", exp_ready, 0);
    check("rst_cmp", cmp_count, 0);
    check("rst_err", err, 0);
    check("rst_uf", underflow, 0);
    check("rst_done", done, 0);
    check("rst_errpc", err_pc, 0);
    resetn = 1'b1;
    #1;
    check("rel_ready", exp_ready, 1);

    // basic match, then empty-FIFO underflow
    push(32'hBFC0_0000, 5'd8, 32'h0000_0011);
    push(32'hBFC0_0004, 5'd9, 32'h0000_0022);
    debug_wb_pc = 32'hBFC0_0000; debug_wb_rf_wen = 4'hF;
    debug_wb_rf_wnum = 5'd8; debug_wb_rf_wdata = 32'h11;
    tick();
    wb_ev(32'hBFC0_0004, 4'hF, 5'd9, 32'h22);
    check("basic_cmp", cmp_count, 2);
    check("basic_err", err, 0);
    wb_ev(32'hBFC0_0008, 4'hF, 5'd5, 32'h33);
    check("uf_flag", underflow, 1);
    check("uf_err", err, 1);
    check("uf_expw", err_exp_wdata, 0);
    check("uf_pc", err_pc, 32'hBFC0_0008);
    check("uf_wnum", err_got_wnum, 5);
    check("uf_cmp", cmp_count, 2);
    check("err_ready", exp_ready, 0);

    // byte mask and event filtering
    do_reset();
    push(32'hBFC0_0010, 5'd3, 32'h1234_5678);
    wb_ev(32'hBFC0_0010, 4'b0011, 5'd3, 32'hFFFF_5678);
    check("mask_cmp", cmp_count, 1);
    check("mask_err", err, 0);
    push(32'hBFC0_0010, 5'd3, 32'h1234_5678);
    wb_ev(32'hBFC0_0010, 4'hF, 5'd0, 32'hDEAD_BEEF);
    wb_ev(32'hBFC0_0010, 4'h0, 5'd3, 32'hDEAD_BEEF);
    check("filt_cmp", cmp_count, 1);
    check("filt_err", err, 0);
    wb_ev(32'hBFC0_0010, 4'hF, 5'd3, 32'hFFFF_5678);
    check("mm_err", err, 1);
    check("mm_uf", underflow, 0);
    check("mm_gotw", err_got_wdata, 32'hFFFF_5678);
    check("mm_expw", err_exp_wdata, 32'h1234_5678);
    check("mm_cmp", cmp_count, 1);

    // fill to full, then simultaneous push/pop at count 7
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      exp_valid = 1'b1;
      exp_pc    = 32'hBFC0_0200 + 32'(4 * i);
      exp_wnum  = 5'(1 + i);
      exp_wdata = 32'(i);
      #1;
      if (exp_ready) n++;
      tick();
    end
    exp_valid = 1'b0;
    check("full_pushes", n, 8);
    check("full_ready", exp_ready, 0);
    wb_ev(32'hBFC0_0200, 4'hF, 5'd1, 32'd0);
    check("pop7_cmp", cmp_count, 1);
    check("pop7_ready", exp_ready, 1);
    exp_valid = 1'b1; exp_pc = 32'hBFC0_0220; exp_wnum = 5'd20; exp_wdata = 32'h99;
    wb_ev(32'hBFC0_0204, 4'hF, 5'd2, 32'd1);
    exp_valid = 1'b0;
    check("pp_cmp", cmp_count, 2);
    check("pp_ready", exp_ready, 1);
    push(32'hBFC0_0224, 5'd21, 32'h98);
    check("pp_full", exp_ready, 0);
    wb_ev(32'hBFC0_0208, 4'hF, 5'd3, 32'd2);
    check("order_cmp", cmp_count, 3);
    check("order_err", err, 0);

    // matching event at end PC
    do_reset();
    push(32'hBFC0_0100, 5'd4, 32'hAA);
    wb_ev(32'hBFC0_0100, 4'hF, 5'd4, 32'hAA);
    check("end_cmp", cmp_count, 1);
    check("end_done", done, 1);
    check("end_ready", exp_ready, 0);
    check("end_err", err, 0);
    wb_ev(32'hBFC0_0300, 4'hF, 5'd7, 32'h1);
    check("done_frz_err", err, 0);
    check("done_frz_cmp", cmp_count, 1);

    // mismatch at end PC: ERR wins
    do_reset();
    push(32'hBFC0_0100, 5'd4, 32'hAA);
    wb_ev(32'hBFC0_0100, 4'hF, 5'd4, 32'hAB);
    check("prio_err", err, 1);
    check("prio_done", done, 0);
    check("prio_pc", err_pc, 32'hBFC0_0100);

    // reset from ERR with three entries queued
    do_reset();
    push(32'hBFC0_0400, 5'd1, 32'h1);
    push(32'hBFC0_0404, 5'd2, 32'h2);
    push(32'hBFC0_0408, 5'd3, 32'h3);
    wb_ev(32'hBFC0_0400, 4'hF, 5'd1, 32'h5);
    check("mid_err", err, 1);
    resetn = 1'b0;
    tick();
    check("mid_rst_ready", exp_ready, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_expw", err_exp_wdata, 0);
    check("mid_rst_gotw", err_got_wdata, 0);
    check("mid_rst_wnum", err_got_wnum, 0);
    check("mid_rst_pc", err_pc, 0);
    resetn = 1'b1;
    #1;
    check("mid_rel_ready", exp_ready, 1);
    wb_ev(32'hBFC0_0400, 4'hF, 5'd1, 32'h1);
    check("mid_empty_uf", underflow, 1);
    check("mid_empty_cmp", cmp_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
